// File: rtl/riscv_cache_writebuffer.sv
// riscv_cache_writebuffer: store write buffer in front of the cache data/tag memories.
// CPU store hits are queued in a DEPTH-entry FIFO. The oldest entry is presented
// as a memory write and retires in any cycle without a memory read.
// Optional store merging into the tail entry is enabled by defining RISCV_WB_MERGE_EN.
//
// Handshakes:
//   Push side: push_i is the valid and ~full_o is the ready. A store is taken when
//   both are high. With merging enabled, a store may also be taken while full_o is
//   high if it merges into the tail entry.
//   Pop side: writebuffer_we_o is the valid and ~rreq_i is the ready. The head
//   entry retires at the clock edge when both are high.
module riscv_cache_writebuffer #(
   parameter int XLEN          = 32,
   parameter int WAYS          = 2,
   parameter int IDX_BITS      = 6,
   parameter int DAT_OFFS_BITS = 2,
   parameter int DEPTH         = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       push_i,
   input  logic [IDX_BITS-1:0]        push_idx_i,
   input  logic [DAT_OFFS_BITS-1:0]   push_offs_i,
   input  logic [XLEN/8-1:0]          push_be_i,
   input  logic [XLEN-1:0]            push_data_i,
   input  logic [WAYS-1:0]            push_ways_hit_i,
   input  logic                       rreq_i,
   input  logic [IDX_BITS-1:0]        rd_idx_i,
   output logic                       writebuffer_we_o,
   output logic [XLEN/8-1:0]          writebuffer_be_o,
   output logic [IDX_BITS-1:0]        writebuffer_idx_o,
   output logic [DAT_OFFS_BITS-1:0]   writebuffer_offs_o,
   output logic [XLEN-1:0]            writebuffer_data_o,
   output logic [WAYS-1:0]            writebuffer_ways_hit_o,
   output logic                       hazard_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int BW = XLEN / 8;

   logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]            count_q, count_d;
   logic [DEPTH-1:0]         valid_q, valid_d;
   logic [IDX_BITS-1:0]      idx_q  [DEPTH];
   logic [IDX_BITS-1:0]      idx_d  [DEPTH];
   logic [DAT_OFFS_BITS-1:0] offs_q [DEPTH];
   logic [DAT_OFFS_BITS-1:0] offs_d [DEPTH];
   logic [BW-1:0]            be_q   [DEPTH];
   logic [BW-1:0]            be_d   [DEPTH];
   logic [XLEN-1:0]          data_q [DEPTH];
   logic [XLEN-1:0]          data_d [DEPTH];
   logic [WAYS-1:0]          ways_q [DEPTH];
   logic [WAYS-1:0]          ways_d [DEPTH];

   logic empty, full, pop, accept;
`ifdef RISCV_WB_MERGE_EN
   logic          merge;
   logic [PW-1:0] tail_ptr;
`endif

   // Full/empty come from the occupancy count, never from pointer equality.
   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));

   // Next-state logic: retire head, merge into tail, allocate new entry.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      valid_d  = valid_q;
      idx_d    = idx_q;
      offs_d   = offs_q;
      be_d     = be_q;
      data_d   = data_q;
      ways_d   = ways_q;

      // Same condition the memory uses to perform the write, so each entry is written once.
      pop = ~empty & ~rreq_i;

`ifdef RISCV_WB_MERGE_EN
      // The tail may only absorb a store if it is not the head that is leaving this cycle.
      tail_ptr = wr_ptr_q - PW'(1);
      merge    = push_i & ~empty
               & ((tail_ptr != rd_ptr_q) | ~pop)
               & (idx_q[tail_ptr]  == push_idx_i)
               & (offs_q[tail_ptr] == push_offs_i)
               & (ways_q[tail_ptr] == push_ways_hit_i);
      accept   = push_i & ~full & ~merge;
      if (merge) begin
         be_d[tail_ptr] = be_q[tail_ptr] | push_be_i;
         for (int b = 0; b < BW; b++) begin
            if (push_be_i[b]) data_d[tail_ptr][b*8 +: 8] = push_data_i[b*8 +: 8];
         end
      end
`else
      // full_o is taken before any same-cycle pop, so a push into a full buffer is dropped.
      accept = push_i & ~full;
`endif

      if (pop) begin
         valid_d[rd_ptr_q] = 1'b0;
         rd_ptr_d          = rd_ptr_q + PW'(1);
      end
      if (accept) begin
         valid_d[wr_ptr_q] = 1'b1;
         idx_d[wr_ptr_q]   = push_idx_i;
         offs_d[wr_ptr_q]  = push_offs_i;
         be_d[wr_ptr_q]    = push_be_i;
         data_d[wr_ptr_q]  = push_data_i;
         ways_d[wr_ptr_q]  = push_ways_hit_i;
         wr_ptr_d          = wr_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(accept) - CW'(pop);
   end

   // Control state with synchronous active-low reset; reset discards all pending stores.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
      end
   end

   // Entry payload storage; contents are only meaningful where the valid bit is set.
   always_ff @(posedge clk_i) begin
      idx_q  <= idx_d;
      offs_q <= offs_d;
      be_q   <= be_d;
      data_q <= data_d;
      ways_q <= ways_d;
   end

   // Read-after-write hazard: any pending entry at the read index, including a head popping now.
   always_comb begin
      hazard_o = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && (idx_q[i] == rd_idx_i)) hazard_o = 1'b1;
      end
   end

   assign writebuffer_we_o       = ~empty;
   assign writebuffer_be_o       = be_q[rd_ptr_q];
   assign writebuffer_idx_o      = idx_q[rd_ptr_q];
   assign writebuffer_offs_o     = offs_q[rd_ptr_q];
   assign writebuffer_data_o     = data_q[rd_ptr_q];
   assign writebuffer_ways_hit_o = ways_q[rd_ptr_q];
   assign full_o                 = full;
   assign empty_o                = empty;
   assign count_o                = count_q;

endmodule

// File: tb/tb_riscv_cache_writebuffer.sv
// Self-checking bench for riscv_cache_writebuffer (default parameters).
// Directed scenarios plus a randomized run against a queue-based reference model.
// Define RISCV_WB_MERGE_EN for both bench and RTL to exercise store merging.
module tb_riscv_cache_writebuffer;

   localparam int DEPTH = 4;
   localparam int EW    = 6 + 2 + 4 + 32 + 2;

   typedef struct packed {
      logic [5:0]  idx;
      logic [1:0]  offs;
      logic [3:0]  be;
      logic [31:0] data;
      logic [1:0]  ways;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        push = 1'b0;
   logic [5:0]  p_idx = '0;
   logic [1:0]  p_offs = '0;
   logic [3:0]  p_be = '0;
   logic [31:0] p_data = '0;
   logic [1:0]  p_ways = '0;
   logic        rreq = 1'b0;
   logic [5:0]  rd_idx = '0;

   logic        we, hazard, full, empty;
   logic [3:0]  be;
   logic [5:0]  idx;
   logic [1:0]  offs;
   logic [31:0] data;
   logic [1:0]  ways;
   logic [2:0]  count;

   // Reference model: pending stores, oldest first.
   logic [EW-1:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;

   riscv_cache_writebuffer dut (
      .clk_i(clk), .rst_ni(rst_n),
      .push_i(push), .push_idx_i(p_idx), .push_offs_i(p_offs), .push_be_i(p_be),
      .push_data_i(p_data), .push_ways_hit_i(p_ways),
      .rreq_i(rreq), .rd_idx_i(rd_idx),
      .writebuffer_we_o(we), .writebuffer_be_o(be), .writebuffer_idx_o(idx),
      .writebuffer_offs_o(offs), .writebuffer_data_o(data), .writebuffer_ways_hit_o(ways),
      .hazard_o(hazard), .full_o(full), .empty_o(empty), .count_o(count)
   );

   // Clock
   always #5 clk = ~clk;

   // Driver: apply the current inputs for one clock edge and advance the model alongside.
   task automatic drive_cycle();
      ent_t e;
      bit   pop_m, mrg, acc;
      int   sz;
      sz = exp_q.size();
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         pop_m = (sz > 0) && !rreq;
         mrg   = 1'b0;
`ifdef RISCV_WB_MERGE_EN
         if (push && sz > 0 && (sz > 1 || !pop_m)) begin
            e = exp_q[sz-1];
            if (e.idx == p_idx && e.offs == p_offs && e.ways == p_ways) begin
               mrg = 1'b1;
               for (int b = 0; b < 4; b++) if (p_be[b]) e.data[b*8 +: 8] = p_data[b*8 +: 8];
               e.be = e.be | p_be;
               exp_q[sz-1] = e;
            end
         end
`endif
         acc = push && !mrg && (sz < DEPTH);
         if (pop_m) void'(exp_q.pop_front());
         if (acc) begin
            e = '{idx: p_idx, offs: p_offs, be: p_be, data: p_data, ways: p_ways};
            exp_q.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_push(input logic [5:0] i, input logic [1:0] o, input logic [3:0] b,
                           input logic [31:0] d, input logic [1:0] w);
      push = 1'b1; p_idx = i; p_offs = o; p_be = b; p_data = d; p_ways = w;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; push = 1'b0; rreq = 1'b0;
      drive_cycle();
      drive_cycle();
      rst_n = 1'b1;
      #1;
      n_checks++; if (we !== 1'b0) $display("FAIL reset_we: got %0h expected 0", we); else n_pass++;
      n_checks++; if (empty !== 1'b1) $display("FAIL reset_empty: got %0h expected 1", empty); else n_pass++;
      n_checks++; if (full !== 1'b0) $display("FAIL reset_full: got %0h expected 0", full); else n_pass++;
      n_checks++; if (hazard !== 1'b0) $display("FAIL reset_hazard: got %0h expected 0", hazard); else n_pass++;
      n_checks++; if (count !== 3'd0) $display("FAIL reset_count: got %0d expected 0", count); else n_pass++;
   endtask

   task automatic test_single();
      rreq = 1'b1;
      set_push(6'd5, 2'd1, 4'hF, 32'hDEADBEEF, 2'b01);
      drive_cycle();
      push = 1'b0;
      #1;
      n_checks++; if (we !== 1'b1) $display("FAIL single_we: got %0h expected 1", we); else n_pass++;
      n_checks++; if (count !== 3'd1) $display("FAIL single_count: got %0d expected 1", count); else n_pass++;
      n_checks++;
      if ({idx, offs, be, data, ways} !== {6'd5, 2'd1, 4'hF, 32'hDEADBEEF, 2'b01})
         $display("FAIL single_fields: got %0h expected %0h", {idx, offs, be, data, ways},
                  {6'd5, 2'd1, 4'hF, 32'hDEADBEEF, 2'b01});
      else n_pass++;
      drive_cycle();
      n_checks++; if ({we, count} !== {1'b1, 3'd1}) $display("FAIL single_hold: got %0h expected 9", {we, count}); else n_pass++;
      rreq = 1'b0;
      drive_cycle();
      n_checks++; if ({we, empty} !== 2'b01) $display("FAIL single_popped: got %0h expected 1", {we, empty}); else n_pass++;
   endtask

   task automatic test_full();
      logic [31:0] d [4];
      rreq = 1'b1;
      for (int i = 0; i < 4; i++) begin
         d[i] = $urandom;
         set_push(6'(10 + i), 2'(i), 4'hF, d[i], 2'b10);
         drive_cycle();
      end
      push = 1'b0;
      #1;
      n_checks++; if ({full, count} !== {1'b1, 3'd4}) $display("FAIL full_flag: got %0h expected c", {full, count}); else n_pass++;
      set_push(6'd20, 2'd0, 4'hF, 32'h12345678, 2'b01);
      drive_cycle();
      push = 1'b0;
      #1;
      n_checks++; if ({count, idx} !== {3'd4, 6'd10}) $display("FAIL full_drop: got %0h expected %0h", {count, idx}, {3'd4, 6'd10}); else n_pass++;
      rreq = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if ({we, idx, data} !== {1'b1, 6'(10 + i), d[i]})
            $display("FAIL full_order%0d: got %0h expected %0h", i, {we, idx, data}, {1'b1, 6'(10 + i), d[i]});
         else n_pass++;
         drive_cycle();
      end
      n_checks++; if (empty !== 1'b1) $display("FAIL full_drained: got %0h expected 1", empty); else n_pass++;
   endtask

   task automatic test_back_to_back();
      rreq = 1'b1;
      set_push(6'd1, 2'd0, 4'h3, 32'h11111111, 2'b01); drive_cycle();
      set_push(6'd2, 2'd0, 4'h3, 32'h22222222, 2'b01); drive_cycle();
      set_push(6'd3, 2'd0, 4'h3, 32'h33333333, 2'b01);
      rreq = 1'b0;
      drive_cycle();
      push = 1'b0;
      #1;
      n_checks++; if ({count, idx} !== {3'd2, 6'd2}) $display("FAIL b2b_count: got %0h expected %0h", {count, idx}, {3'd2, 6'd2}); else n_pass++;
      drive_cycle();
      n_checks++; if ({we, idx, data} !== {1'b1, 6'd3, 32'h33333333}) $display("FAIL b2b_order: got %0h expected %0h", {we, idx, data}, {1'b1, 6'd3, 32'h33333333}); else n_pass++;
      drive_cycle();
      n_checks++; if (empty !== 1'b1) $display("FAIL b2b_drained: got %0h expected 1", empty); else n_pass++;
   endtask

   task automatic test_hazard();
      rreq = 1'b1;
      set_push(6'd3, 2'd0, 4'hF, 32'hA, 2'b01); drive_cycle();
      set_push(6'd9, 2'd1, 4'hF, 32'hB, 2'b10); drive_cycle();
      push = 1'b0;
      rd_idx = 6'd9; #1;
      n_checks++; if (hazard !== 1'b1) $display("FAIL hazard_9: got %0h expected 1", hazard); else n_pass++;
      rd_idx = 6'd4; #1;
      n_checks++; if (hazard !== 1'b0) $display("FAIL hazard_4: got %0h expected 0", hazard); else n_pass++;
      rd_idx = 6'd3; #1;
      n_checks++; if (hazard !== 1'b1) $display("FAIL hazard_3: got %0h expected 1", hazard); else n_pass++;
      rreq = 1'b0;
      drive_cycle();
      drive_cycle();
      n_checks++; if ({hazard, empty} !== 2'b01) $display("FAIL hazard_empty: got %0h expected 1", {hazard, empty}); else n_pass++;
   endtask

   task automatic test_reset_mid();
      rreq = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_push(6'(20 + i), 2'd0, 4'hF, $urandom, 2'b01);
         drive_cycle();
      end
      push = 1'b0;
      #1;
      n_checks++; if (count !== 3'd3) $display("FAIL rstmid_pre: got %0d expected 3", count); else n_pass++;
      rst_n = 1'b0;
      drive_cycle();
      rst_n = 1'b1;
      #1;
      n_checks++; if ({we, count} !== 4'h0) $display("FAIL rstmid_post: got %0h expected 0", {we, count}); else n_pass++;
      rreq = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive_cycle();
         n_checks++; if (we !== 1'b0) $display("FAIL rstmid_nowrite%0d: got %0h expected 0", i, we); else n_pass++;
      end
   endtask

   task automatic test_merge();
      rreq = 1'b1;
      set_push(6'd7, 2'd2, 4'h1, 32'h000000AA, 2'b01); drive_cycle();
      set_push(6'd7, 2'd2, 4'h4, 32'h00CC0000, 2'b01); drive_cycle();
      push = 1'b0;
      #1;
`ifdef RISCV_WB_MERGE_EN
      n_checks++; if (count !== 3'd1) $display("FAIL merge_count: got %0d expected 1", count); else n_pass++;
      n_checks++; if (be !== 4'h5) $display("FAIL merge_be: got %0h expected 5", be); else n_pass++;
      n_checks++;
      if ({data[23:16], data[7:0]} !== 16'hCCAA) $display("FAIL merge_data: got %0h expected ccaa", {data[23:16], data[7:0]});
      else n_pass++;
`else
      n_checks++; if (count !== 3'd2) $display("FAIL merge_count: got %0d expected 2", count); else n_pass++;
      n_checks++; if ({be, data[7:0]} !== 12'h1AA) $display("FAIL merge_head: got %0h expected 1aa", {be, data[7:0]}); else n_pass++;
`endif
      rreq = 1'b0;
      drive_cycle();
      drive_cycle();
      n_checks++; if (empty !== 1'b1) $display("FAIL merge_drained: got %0h expected 1", empty); else n_pass++;
   endtask

   task automatic test_random();
      ent_t h;
      logic exp_hz;
      int   sz;
      for (int c = 0; c < 400; c++) begin
         rst_n  = ($urandom_range(0, 79) != 0);
         rreq   = ($urandom_range(0, 2) == 0);
         push   = ($urandom_range(0, 9) < 6);
         p_idx  = 6'($urandom_range(0, 3));
         p_offs = 2'($urandom_range(0, 1));
         p_be   = 4'($urandom_range(0, 15));
         p_data = $urandom;
         p_ways = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
         rd_idx = 6'($urandom_range(0, 4));
         #1;
         sz = exp_q.size();
         exp_hz = 1'b0;
         foreach (exp_q[k]) begin
            h = exp_q[k];
            if (h.idx == rd_idx) exp_hz = 1'b1;
         end
         n_checks++;
         if ({we, full, empty, hazard, count} !== {sz > 0, sz == DEPTH, sz == 0, exp_hz, 3'(sz)})
            $display("FAIL rand_status c%0d: got %0h expected %0h", c, {we, full, empty, hazard, count},
                     {sz > 0, sz == DEPTH, sz == 0, exp_hz, 3'(sz)});
         else n_pass++;
         if (sz > 0) begin
            h = exp_q[0];
            n_checks++;
            if ({idx, offs, be, data, ways} !== h)
               $display("FAIL rand_head c%0d: got %0h expected %0h", c, {idx, offs, be, data, ways}, h);
            else n_pass++;
         end
         drive_cycle();
      end
      rst_n = 1'b1;
      push  = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_full();
      test_back_to_back();
      test_hazard();
      test_reset_mid();
      test_merge();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
